// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the fetch (I) and data (D)
// requesters, with alternating priority when both ask in the same cycle.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CW = $clog2(MEM_LATENCY) + 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   count;
   logic            owner;
   logic            last_grant;
   logic            any_req;
   logic            grant_d;

   // owner / last_grant encoding: 1 = D, 0 = I
   assign any_req = i_req | d_req;
   assign grant_d = d_req & (~i_req | ~last_grant);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = BUSY;
         BUSY:    if (count == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_req = (state == BUSY);
   assign i_ack   = (state == DONE) & ~owner;
   assign d_ack   = (state == DONE) & owner;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_req) begin
            owner      <= grant_d;
            last_grant <= grant_d;
            count      <= CW'(MEM_LATENCY - 1);
            mem_we     <= grant_d & d_we;
            mem_addr   <= grant_d ? d_addr : i_addr;
            mem_wdata  <= grant_d ? d_wdata : '0;
         end else if (state == BUSY) begin
            if (count != '0) begin
               count <= count - CW'(1);
            end else if (!mem_we) begin
               if (owner) d_rdata <= mem_rdata;
               else       i_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomised checks of mem_port_arbiter against a small
// word-addressed memory model and a shadow copy of its contents.
module tb_mem_port_arbiter;

   logic        clock;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem    [0:255];
   logic [31:0] shadow [0:255];

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .MEM_LATENCY(5)
   ) dut (
      .clock(clock),
      .reset(reset),
      .i_req(i_req),
      .i_addr(i_addr),
      .i_ack(i_ack),
      .i_rdata(i_rdata),
      .d_req(d_req),
      .d_we(d_we),
      .d_addr(d_addr),
      .d_wdata(d_wdata),
      .d_ack(d_ack),
      .d_rdata(d_rdata),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign mem_rdata = mem_req ? mem[mem_addr[9:2]] : 32'h0;

   always @(posedge clock) begin
      if (mem_req && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one request, hold it until its ack, and measure the access.
   task automatic run_access(input logic is_d, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output int busy,
                             output int wecnt, output int bad);
      lat = 0; busy = 0; wecnt = 0; bad = 0;
      @(negedge clock);
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         if (mem_req) busy++;
         if (mem_req && mem_we) wecnt++;
         if (is_d ? i_ack : d_ack) bad++;
         if (is_d ? d_ack : i_ack) begin
            lat = k;
            break;
         end
      end
      i_req = 1'b0;
      d_req = 1'b0;
      d_we  = 1'b0;
   endtask

   int lat, busy, wecnt, bad;
   int ack_t [4];
   logic ack_d [4];
   int n_ack, overlaps, cnt;
   int i_wait, d_wait, max_wait;
   int i_iss, i_done, d_iss, d_done;
   logic [31:0] i_a, d_a, d_wd;
   logic d_w;

   initial begin
      for (int j = 0; j < 256; j++) begin
         mem[j]    = 32'hA5000000 | 32'(j);
         shadow[j] = 32'hA5000000 | 32'(j);
      end
      mem[8'h10] = 32'h1234_5678;
      shadow[8'h10] = 32'h1234_5678;
      mem[8'h20] = 32'hCAFE_0001;
      shadow[8'h20] = 32'hCAFE_0001;
      mem[8'h80] = 32'h5555_5555;
      shadow[8'h80] = 32'h5555_5555;

      reset = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (2) @(negedge clock);
      check("rst_mem_req", mem_req, 0);
      check("rst_acks", {i_ack, d_ack}, 0);
      check("rst_rdata", {i_rdata, d_rdata}, 0);
      check("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
      reset = 1'b0;

      // single fetch read
      run_access(1'b0, 1'b0, 32'h40, 32'h0, lat, busy, wecnt, bad);
      check("t1_latency", lat, 6);
      check("t1_busy", busy, 5);
      check("t1_no_d_ack", bad, 0);
      check("t1_i_rdata", i_rdata, 32'h1234_5678);

      // data read to give d_rdata a known value, then a write
      run_access(1'b1, 1'b0, 32'h80, 32'h0, lat, busy, wecnt, bad);
      check("t2_pre_read", d_rdata, 32'hCAFE_0001);
      run_access(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, lat, busy, wecnt, bad);
      check("t2_latency", lat, 6);
      check("t2_we_cycles", wecnt, 5);
      check("t2_no_i_ack", bad, 0);
      check("t2_d_rdata_hold", d_rdata, 32'hCAFE_0001);
      check("t2_i_rdata_hold", i_rdata, 32'h1234_5678);
      shadow[8'h40] = 32'hDEAD_BEEF;
      run_access(1'b1, 1'b0, 32'h100, 32'h0, lat, busy, wecnt, bad);
      check("t2_readback", d_rdata, 32'hDEAD_BEEF);

      // address change during BUSY is ignored
      @(negedge clock);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      cnt = 0; lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         if (k == 2) d_addr = 32'h200;
         if (mem_req && mem_addr == 32'h100) cnt++;
         if (d_ack) begin
            lat = k;
            break;
         end
      end
      d_req = 1'b0;
      check("t4_addr_stable", cnt, 5);
      check("t4_latency", lat, 6);
      check("t4_d_rdata", d_rdata, 32'hDEAD_BEEF);

      // reset in the third BUSY cycle aborts the access
      @(negedge clock);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
      repeat (3) @(negedge clock);
      check("t5_busy_before", mem_req, 1);
      reset = 1'b1;
      #1;
      check("t5_mem_req_drop", mem_req, 0);
      check("t5_acks_zero", {i_ack, d_ack}, 0);
      check("t5_rdata_zero", {i_rdata, d_rdata}, 0);
      check("t5_bus_zero", {mem_we, mem_addr, mem_wdata}, 0);
      d_req = 1'b0;
      cnt = 0;
      repeat (3) begin
         @(negedge clock);
         if (i_ack || d_ack || mem_req) cnt++;
      end
      check("t5_quiet_in_reset", cnt, 0);
      reset = 1'b0;
      run_access(1'b0, 1'b0, 32'h40, 32'h0, lat, busy, wecnt, bad);
      check("t5_after_latency", lat, 6);
      check("t5_after_rdata", i_rdata, 32'h1234_5678);

      // both requesters held: D wins first, then alternate
      @(negedge clock);
      i_req = 1'b1; i_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      n_ack = 0; overlaps = 0;
      for (int k = 1; k <= 40 && n_ack < 4; k++) begin
         @(negedge clock);
         if (i_ack && d_ack) overlaps++;
         if (i_ack || d_ack) begin
            ack_t[n_ack] = k;
            ack_d[n_ack] = d_ack;
            n_ack++;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      check("t3_ack_count", n_ack, 4);
      check("t3_order", {ack_d[0], ack_d[1], ack_d[2], ack_d[3]}, 4'b1010);
      check("t3_overlap", overlaps, 0);
      check("t3_first_lat", ack_t[0], 6);
      check("t3_gap1", ack_t[1] - ack_t[0], 7);
      check("t3_gap2", ack_t[2] - ack_t[1], 7);
      check("t3_gap3", ack_t[3] - ack_t[2], 7);
      check("t3_i_rdata", i_rdata, 32'h1234_5678);
      check("t3_d_rdata", d_rdata, 32'hDEAD_BEEF);

      // random traffic against the shadow memory
      i_wait = 0; d_wait = 0; max_wait = 0; overlaps = 0;
      i_iss = 0; i_done = 0; d_iss = 0; d_done = 0;
      i_a = '0; d_a = '0; d_wd = '0; d_w = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clock);
         if (i_req) i_wait++;
         if (d_req) d_wait++;
         if (i_ack && d_ack) overlaps++;
         if (i_ack) begin
            check("rnd_i_data", i_rdata, shadow[i_a[9:2]]);
            if (i_wait > max_wait) max_wait = i_wait;
            i_req = 1'b0;
            i_done++;
         end else if (!i_req && k < 550 && $urandom_range(0, 2) == 0) begin
            i_a = 32'($urandom_range(0, 63)) << 2;
            i_addr = i_a;
            i_req = 1'b1;
            i_wait = 0;
            i_iss++;
         end
         if (d_ack) begin
            if (d_w) shadow[d_a[9:2]] = d_wd;
            else check("rnd_d_data", d_rdata, shadow[d_a[9:2]]);
            if (d_wait > max_wait) max_wait = d_wait;
            d_req = 1'b0;
            d_we = 1'b0;
            d_done++;
         end else if (!d_req && k < 550 && $urandom_range(0, 2) == 0) begin
            d_a = 32'($urandom_range(0, 63)) << 2;
            d_w = 1'($urandom_range(0, 1));
            d_wd = $urandom;
            d_addr = d_a; d_we = d_w; d_wdata = d_wd;
            d_req = 1'b1;
            d_wait = 0;
            d_iss++;
         end
      end
      check("rnd_i_all_acked", i_done, i_iss);
      check("rnd_d_all_acked", d_done, d_iss);
      check("rnd_overlap", overlaps, 0);
      check("rnd_max_wait_ok", max_wait <= 13, 1);
      check("rnd_idle_end", {mem_req, i_ack, d_ack}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
